// File: rtl/pc_fetch_ctrl.sv
// Fetch/PC sequencer: issues one fetch at a time, holds the instruction until
// execute completes, then forms the next PC. PCFETCH_PERF_EN adds perf counters.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h8000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        exec_done,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    input  logic        halt,
    output logic        trap,
    output logic [31:0] trap_epc,
`ifdef PCFETCH_PERF_EN
    output logic [63:0] perf_cycles,
    output logic [63:0] perf_retired,
`endif
    output logic        halted
);

    typedef enum logic [1:0] {StReq, StWait, StExec, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        req_valid_q, req_valid_d;
    logic        inst_valid_q, inst_valid_d;
    logic        trap_q, trap_d;
    logic [31:0] trap_epc_q, trap_epc_d;
    logic        halted_q, halted_d;
    logic [31:0] target;
    logic        retire;

    assign retire = (state_q == StExec) && exec_done;

    always_comb begin
        case (pc_src)
            2'b01:   target = pc_q + imm;
            2'b10:   target = (rs1_val + imm) & 32'hFFFF_FFFE;
            default: target = pc_q + 32'd4;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        trap_d     = 1'b0;
        trap_epc_d = trap_epc_q;
        halted_d   = halted_q;
        unique case (state_q)
            StReq: begin
                // req_valid_q gates the handshake so nothing is accepted the cycle after reset
                if (req_valid_q && imem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    inst_d    = imem_rsp_data;
                    inst_pc_d = pc_q;
                    state_d   = StExec;
                end
            end
            StExec: begin
                if (exec_done) begin
                    if (halt) begin
                        halted_d = 1'b1;
                        state_d  = StHalt;
                    end else if (target[1:0] != 2'b00) begin
                        trap_d     = 1'b1;
                        trap_epc_d = target;
                        pc_d       = TRAP_PC;
                        state_d    = StReq;
                    end else begin
                        pc_d    = target;
                        state_d = StReq;
                    end
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StReq;
        endcase
        req_valid_d  = (state_d == StReq);
        inst_valid_d = (state_d == StExec);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            trap_q       <= 1'b0;
            trap_epc_q   <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
            trap_q       <= trap_d;
            trap_epc_q   <= trap_epc_d;
            halted_q     <= halted_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_valid     = inst_valid_q;
    assign trap           = trap_q;
    assign trap_epc       = trap_epc_q;
    assign halted         = halted_q;

`ifdef PCFETCH_PERF_EN
    logic [63:0] perf_cycles_q, perf_cycles_d;
    logic [63:0] perf_retired_q, perf_retired_d;

    always_comb begin
        perf_cycles_d  = perf_cycles_q;
        perf_retired_d = perf_retired_q;
        if (state_q != StHalt) begin
            perf_cycles_d = perf_cycles_q + 64'd1;
        end
        if (retire) begin
            perf_retired_d = perf_retired_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cycles_q  <= '0;
            perf_retired_q <= '0;
        end else begin
            perf_cycles_q  <= perf_cycles_d;
            perf_retired_q <= perf_retired_d;
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_retired = perf_retired_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Multi-cycle fetch/PC sequencer for the npc core. Owns the architectural PC and issues instruction-fetch requests to instruction memory over a valid/ready handshake. Presents each fetched instruction to the decode/execute datapath. On execute completion it takes the 2-bit next-PC select from the branch decision logic and forms the next PC (pc+4 / pc+imm / rs1+imm), trapping on misaligned targets and halting on ebreak.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset
TRAP_PC, 32'h8000_0100, PC loaded on misaligned-target trap

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous reset, active low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  instruction memory accepts request
imem_addr  out  32  fetch address (= current PC)
imem_rsp_valid  in  1  fetch response valid, single-cycle pulse
imem_rsp_data  in  32  fetched instruction
inst  out  32  instruction presented to datapath
inst_pc  out  32  PC of inst
inst_valid  out  1  inst/inst_pc valid, held until exec_done
exec_done  in  1  datapath finished current instruction
pc_src  in  2  00 pc+4, 01 pc+imm, 10 rs1+imm, 11 treated as 00
imm  in  32  immediate from decode
rs1_val  in  32  rs1 operand
halt  in  1  current instruction is ebreak; sampled with exec_done
trap  out  1  misaligned-target trap pulse, 1 cycle
trap_epc  out  32  target address that caused the trap, held until the next trap
halted  out  1  sticky, core stopped

Behaviour:
- States: S_REQ, S_WAIT, S_EXEC, S_HALT. Reset → S_REQ, pc=RESET_PC. All outputs are 0 in reset except imem_addr, which equals RESET_PC.
- All outputs are registered or decoded from state only. No combinational path from any input to any output.
- S_REQ: imem_req_valid=1 and imem_addr=pc. Both are held stable until imem_req_valid & imem_req_ready. On that handshake → S_WAIT.
- imem_rsp_valid is ignored in any state other than S_WAIT.
- S_WAIT: on imem_rsp_valid, capture inst<=imem_rsp_data and inst_pc<=pc, assert inst_valid, → S_EXEC. The response may arrive in the cycle immediately after the accept, giving minimum latency REQ→EXEC = 2 cycles.
- S_EXEC: inst_valid=1, and inst/inst_pc are stable. Wait for exec_done. On exec_done, inst_valid drops the next cycle.
- Target computation:
  - 00/11 → pc+4
  - 01 → pc+imm
  - 10 → (rs1_val+imm) & ~1
  - All arithmetic is 32-bit modulo; wrap past 32'hFFFF_FFFC is allowed.
- On exec_done in S_EXEC:
  - halt=1 → S_HALT, halted<=1. pc is unchanged and halt takes priority over any target.
  - else target[1:0]!=0 → trap pulses 1 for one cycle, trap_epc<=target, pc<=TRAP_PC, → S_REQ.
  - else pc<=target, → S_REQ.
- S_HALT: absorbing state. No requests issued. Only rst_n leaves it.
- exec_done outside S_EXEC is ignored.
- Reset mid-operation (any state, including an outstanding fetch) returns to S_REQ with pc=RESET_PC. A stale response arriving after reset lands in S_REQ and is ignored.
- One fetch is outstanding at most. There is no prefetch or speculation.

Optional Feature:
PCFETCH_PERF_EN
- Defined: adds outputs perf_cycles[63:0] and perf_retired[63:0], both reset to 0.
  - perf_cycles increments every cycle while not in S_HALT.
  - perf_retired increments on each exec_done in S_EXEC, including trapping and halting instructions.
  - Both counters wrap modulo 2^64.
- Undefined: these ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset release with imem_req_ready=1: first imem_addr=32'h8000_0000. Response 32'h0000_0013 with 1-cycle latency gives inst_valid with inst=32'h13 and inst_pc=32'h8000_0000. exec_done with pc_src=00 gives next imem_addr=32'h8000_0004.
- pc=32'h8000_0010, pc_src=01, imm=32'hFFFF_FFF0 → next fetch at 32'h8000_0000. pc_src=10, rs1_val=32'h8000_0201, imm=0 → next fetch at 32'h8000_0200 (LSB cleared).
- pc=32'h8000_0000, pc_src=01, imm=32'h2 → trap high exactly 1 cycle, trap_epc=32'h8000_0002, next fetch at 32'h8000_0100.
- imem_req_ready held 0 for 5 cycles: imem_req_valid stays 1 and imem_addr stays stable. A spurious imem_rsp_valid during S_REQ does not change inst or inst_valid.
- exec_done with halt=1 and pc_src=01: halted=1, no further imem_req_valid. rst_n low for 1 cycle then high restarts fetch at RESET_PC with halted=0.
- rst_n asserted while in S_WAIT: next state S_REQ at RESET_PC. A response pulse one cycle after reset release is ignored, and inst_valid stays 0 until the new fetch returns.
